vga_tilemap_avl_ctrl: RTL and testbench



---
 rtl/vga_tilemap_avl_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_tilemap_avl_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_tilemap_avl_ctrl.sv
// Avalon-MM tile-map VGA engine: byte-per-cell tile RAM, palette, CTRL/STATUS, 3-tick pixel pipeline.
// Optional vertical row scroll in CTRL[23:16] when VGA_TILE_SCROLL_EN is defined.
module vga_tilemap_avl_ctrl #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int CELL_W    = 8,
  parameter int CELL_H    = 16,
  parameter int PAL_DEPTH = 16,
  parameter int ADDR_W    = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  input  logic              PIX_EN,
  input  logic              BLANK_N,
  input  logic [9:0]        DRAW_X,
  input  logic [9:0]        DRAW_Y,
  output logic [3:0]        RED,
  output logic [3:0]        GREEN,
  output logic [3:0]        BLUE,
  output logic              FRAME_IRQ
);
  localparam int CW_L  = $clog2(CELL_W);
  localparam int CH_L  = $clog2(CELL_H);
  localparam int PAL_W = $clog2(PAL_DEPTH);
  localparam int TW_W  = ADDR_W - 1;
  localparam int TW    = 1 << TW_W;
  localparam logic [10:0] COLS_V = 11'(COLS);
  localparam logic [10:0] ROWS_V = 11'(ROWS);
  localparam logic [8:0]  PAL_V  = 9'(PAL_DEPTH);

  logic            w_wr, w_rd, w_reg, w_pal_hit;
  logic [7:0]      w_off;
  logic [TW_W-1:0] w_tile_a;
  logic [31:0]     w_reg_rd, w_ctrl;
  logic [7:0]      w_ctrl_scroll;

  logic [11:0]     r_pal [PAL_DEPTH];
  logic [11:0]     r_bg;
  logic            r_en;
  logic            r_sel_tile;
  logic [31:0]     r_reg_rd;
  logic [31:0]     r_rd_a, r_rd_b;

  logic [9:0]      r_prev_y;
  logic            r_vs_tog, r_irq;
  logic [15:0]     r_frame_cnt;
  logic            w_vs;

  assign w_wr      = AVL_CS & AVL_WRITE;
  assign w_rd      = AVL_CS & AVL_READ;
  assign w_reg     = AVL_ADDR[ADDR_W-1];
  assign w_off     = AVL_ADDR[7:0];
  assign w_tile_a  = AVL_ADDR[TW_W-1:0];
  assign w_pal_hit = {1'b0, w_off} < PAL_V;

  // ---------------- pixel stage T1: grid coordinates and word address
  logic [10:0] w_col, w_row, w_row_eff;
  logic [21:0] w_idx;
  logic        w_ingrid;

  assign w_col    = {1'b0, DRAW_X >> CW_L};
  assign w_row    = {1'b0, DRAW_Y >> CH_L};
  assign w_ingrid = (w_col < COLS_V) && (w_row < ROWS_V);

`ifdef VGA_TILE_SCROLL_EN
  logic [7:0]  r_scroll;
  logic [10:0] w_scroll, w_row_sum;
  // Clamp first so one conditional subtract always lands inside [0, ROWS).
  assign w_scroll      = ({3'b0, r_scroll} >= ROWS_V) ? ROWS_V - 11'd1 : {3'b0, r_scroll};
  assign w_row_sum     = w_row + w_scroll;
  assign w_row_eff     = (w_row_sum >= ROWS_V) ? w_row_sum - ROWS_V : w_row_sum;
  assign w_ctrl_scroll = r_scroll;
`else
  assign w_row_eff     = w_row;
  assign w_ctrl_scroll = 8'd0;
`endif

  assign w_idx = 22'(w_row_eff) * 22'(COLS) + 22'(w_col);

  logic [TW_W-1:0] r1_word;
  logic [1:0]      r1_sel, r2_sel;
  logic            r1_valid, r1_blank_n, r1_ingrid;
  logic            r2_valid, r2_blank_n, r2_ingrid;
  logic [11:0]     r_rgb;
  logic [7:0]      w_cell;
  logic [11:0]     w_color;

  // ---------------- tile RAM: one byte lane per cell slot, Avalon on A, pixels on B
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [TW];
    always_ff @(posedge CLK) begin
      if (w_wr && !w_reg && AVL_BYTE_EN[gi])
        r_mem[w_tile_a] <= AVL_WRITEDATA[8*gi +: 8];
      if (w_rd)
        r_rd_a[8*gi +: 8] <= r_mem[w_tile_a];
      if (PIX_EN)
        r_rd_b[8*gi +: 8] <= r_mem[r1_word];
    end
  end

  // ---------------- pixel pipeline T1/T2 flags and T3 colour register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r1_word    <= '0;
      r1_sel     <= 2'd0;
      r1_valid   <= 1'b0;
      r1_blank_n <= 1'b0;
      r1_ingrid  <= 1'b0;
      r2_sel     <= 2'd0;
      r2_valid   <= 1'b0;
      r2_blank_n <= 1'b0;
      r2_ingrid  <= 1'b0;
      r_rgb      <= 12'd0;
    end else if (PIX_EN) begin
      r1_word    <= w_idx[TW_W+1:2];
      r1_sel     <= w_idx[1:0];
      r1_valid   <= 1'b1;
      r1_blank_n <= BLANK_N;
      r1_ingrid  <= w_ingrid;
      r2_sel     <= r1_sel;
      r2_valid   <= r1_valid;
      r2_blank_n <= r1_blank_n;
      r2_ingrid  <= r1_ingrid;
      r_rgb      <= w_color;
    end
  end

  assign w_cell = r_rd_b[{r2_sel, 3'b000} +: 8];

  always_comb begin
    w_color = 12'd0;
    if (r2_valid && r2_blank_n) begin
      if (!r_en || w_cell[7] || !r2_ingrid)
        w_color = r_bg;
      else
        w_color = r_pal[w_cell[PAL_W-1:0]];
    end
  end

  // ---------------- register file
  assign w_ctrl = {8'd0, w_ctrl_scroll, 3'd0, r_en, r_bg};

  always_comb begin
    w_reg_rd = 32'd0;
    if (w_pal_hit)
      w_reg_rd = {20'd0, r_pal[w_off[PAL_W-1:0]]};
    else if (w_off == 8'h80)
      w_reg_rd = w_ctrl;
    else if (w_off == 8'h81)
      w_reg_rd = {r_frame_cnt, 15'd0, r_vs_tog};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < PAL_DEPTH; i++)
        r_pal[i] <= 12'd0;
      r_bg       <= 12'd0;
      r_en       <= 1'b0;
`ifdef VGA_TILE_SCROLL_EN
      r_scroll   <= 8'd0;
`endif
      r_sel_tile <= 1'b0;
      r_reg_rd   <= 32'd0;
    end else begin
      if (w_wr && w_reg) begin
        if (w_pal_hit) begin
          if (AVL_BYTE_EN[0]) r_pal[w_off[PAL_W-1:0]][7:0]  <= AVL_WRITEDATA[7:0];
          if (AVL_BYTE_EN[1]) r_pal[w_off[PAL_W-1:0]][11:8] <= AVL_WRITEDATA[11:8];
        end else if (w_off == 8'h80) begin
          if (AVL_BYTE_EN[0]) r_bg[7:0] <= AVL_WRITEDATA[7:0];
          if (AVL_BYTE_EN[1]) begin
            r_bg[11:8] <= AVL_WRITEDATA[11:8];
            r_en       <= AVL_WRITEDATA[12];
          end
`ifdef VGA_TILE_SCROLL_EN
          if (AVL_BYTE_EN[2]) r_scroll <= AVL_WRITEDATA[23:16];
`endif
        end
      end
      if (w_rd) begin
        r_sel_tile <= !w_reg;
        r_reg_rd   <= w_reg_rd;
      end
    end
  end

  assign AVL_READDATA = r_sel_tile ? r_rd_a : r_reg_rd;

  // ---------------- vsync detection: DRAW_Y entering 480 on a pixel tick
  assign w_vs = PIX_EN && (DRAW_Y == 10'd480) && (r_prev_y != 10'd480);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prev_y    <= 10'd0;
      r_vs_tog    <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= w_vs;
      if (PIX_EN)
        r_prev_y <= DRAW_Y;
      if (w_vs) begin
        r_vs_tog    <= ~r_vs_tog;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign RED       = r_rgb[11:8];
  assign GREEN     = r_rgb[7:4];
  assign BLUE      = r_rgb[3:0];
  assign FRAME_IRQ = r_irq;

  logic w_unused;
  assign w_unused = ^{AVL_WRITEDATA, AVL_ADDR, w_idx, w_cell};
endmodule

// File: tb/tb_vga_tilemap_avl_ctrl.sv
// Directed bench for vga_tilemap_avl_ctrl (COLS=4 build); scroll steps run when VGA_TILE_SCROLL_EN is defined.
module tb_vga_tilemap_avl_ctrl;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
  logic [3:0]  AVL_BYTE_EN = 4'h0;
  logic [10:0] AVL_ADDR = 11'd0;
  logic [31:0] AVL_WRITEDATA = 32'd0;
  logic [31:0] AVL_READDATA;
  logic        PIX_EN = 1'b0, BLANK_N = 1'b0;
  logic [9:0]  DRAW_X = 10'd0, DRAW_Y = 10'd0;
  logic [3:0]  RED, GREEN, BLUE;
  logic        FRAME_IRQ;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  logic [31:0] rd;

  vga_tilemap_avl_ctrl #(.COLS(4), .ROWS(30), .CELL_W(8), .CELL_H(16), .PAL_DEPTH(16), .ADDR_W(11)) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA),
    .PIX_EN(PIX_EN), .BLANK_N(BLANK_N), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .FRAME_IRQ(FRAME_IRQ)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (FRAME_IRQ === 1'b1) irq_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic avl_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
    $display("WR addr=%h data=%h be=%b", a, d, be);
  endtask

  task automatic avl_read(input logic [10:0] a, output logic [31:0] d);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
    $display("RD addr=%h data=%h", a, d);
  endtask

  task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic b);
    DRAW_X = x; DRAW_Y = y; BLANK_N = b; PIX_EN = 1'b1;
    @(posedge CLK); #1;
    PIX_EN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic pix3(input logic [9:0] x, input logic [9:0] y, input logic b);
    tick(x, y, b); tick(x, y, b); tick(x, y, b);
    $display("PIX x=%0d y=%0d blank_n=%b rgb=%h%h%h", x, y, b, RED, GREEN, BLUE);
  endtask

  function automatic logic [31:0] rgb();
    return {20'd0, RED, GREEN, BLUE};
  endfunction

  initial begin
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // reset state
    chk("rst_rgb", rgb(), 32'h0);
    chk("rst_readdata", AVL_READDATA, 32'h0);
    chk("rst_irq", {31'd0, FRAME_IRQ}, 32'h0);
    avl_read(11'h481, rd); chk("rst_status", rd, 32'h0);
    avl_read(11'h480, rd); chk("rst_ctrl", rd, 32'h0);
    avl_read(11'h403, rd); chk("rst_pal3", rd, 32'h0);

    // tile RAM byte enables and read latency
    avl_write(11'd5, 32'h0, 4'hF);
    avl_write(11'd5, 32'hA1B2C3D4, 4'b0101);
    avl_write(11'd6, 32'h0, 4'hF);
    avl_write(11'd6, 32'hA1B2C3D4, 4'b1010);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 11'd5;
    #1 chk("rd_before_edge", AVL_READDATA, 32'h0);
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    chk("tile_w5", AVL_READDATA, 32'h00B200D4);
    @(posedge CLK); #1;
    chk("tile_w5_hold", AVL_READDATA, 32'h00B200D4);
    avl_read(11'd6, rd); chk("tile_w6", rd, 32'hA100C300);

    // palette path
    avl_write(11'h403, 32'hFFFFF0F0, 4'hF);
    avl_write(11'h480, 32'h00001000, 4'hF);
    avl_write(11'd0, 32'h00138303, 4'hF);
    avl_read(11'h403, rd); chk("pal3_rd", rd, 32'h000000F0);
    pix3(10'd0, 10'd0, 1'b1);  chk("pix_0_0", rgb(), 32'h0F0);
    pix3(10'd7, 10'd15, 1'b1); chk("pix_7_15", rgb(), 32'h0F0);
    pix3(10'd16, 10'd0, 1'b1); chk("pix_idx_mask", rgb(), 32'h0F0);

    // background, blanking, latency, display disable
    avl_write(11'h480, 32'h00001ABC, 4'hF);
    pix3(10'd8, 10'd0, 1'b1); chk("bg_cell_b7", rgb(), 32'hABC);
    pix3(10'd8, 10'd0, 1'b0); chk("blank", rgb(), 32'h0);
    tick(10'd0, 10'd0, 1'b1); tick(10'd0, 10'd0, 1'b1);
    chk("latency_2ticks", rgb(), 32'h0);
    tick(10'd0, 10'd0, 1'b1);
    chk("latency_3ticks", rgb(), 32'h0F0);
    avl_write(11'h480, 32'h00000ABC, 4'hF);
    pix3(10'd0, 10'd0, 1'b1); chk("disp_off", rgb(), 32'hABC);

    // out of grid, unmapped, read-only STATUS, CTRL byte enables
    avl_write(11'h480, 32'h00001ABC, 4'hF);
    pix3(10'd40, 10'd0, 1'b1); chk("out_of_grid", rgb(), 32'hABC);
    avl_read(11'h440, rd); chk("unmapped_rd", rd, 32'h0);
    avl_write(11'h440, 32'hFFFFFFFF, 4'hF);
    avl_read(11'h480, rd); chk("unmapped_ctrl", rd, 32'h00001ABC);
    avl_read(11'h403, rd); chk("unmapped_pal", rd, 32'h000000F0);
    avl_read(11'h440, rd); chk("unmapped_rd2", rd, 32'h0);
    avl_write(11'h481, 32'hFFFFFFFF, 4'hF);
    avl_read(11'h481, rd); chk("status_ro", rd, 32'h0);
    avl_write(11'h480, 32'hFFFFFFFF, 4'b0101);
`ifdef VGA_TILE_SCROLL_EN
    avl_read(11'h480, rd); chk("ctrl_be", rd, 32'h00FF1AFF);
`else
    avl_read(11'h480, rd); chk("ctrl_be", rd, 32'h00001AFF);
`endif
    avl_write(11'h480, 32'h00001ABC, 4'hF);

    // vsync over two frames
    tick(10'd0, 10'd479, 1'b0);
    chk("irq_none", irq_cnt, 0);
    tick(10'd0, 10'd480, 1'b0);
    tick(10'd0, 10'd480, 1'b0); tick(10'd0, 10'd480, 1'b0); tick(10'd0, 10'd480, 1'b0);
    avl_read(11'h481, rd); chk("status_f1", rd, 32'h00010001);
    chk("irq_f1", irq_cnt, 1);
    tick(10'd0, 10'd479, 1'b0);
    tick(10'd0, 10'd480, 1'b0); tick(10'd0, 10'd480, 1'b0);
    avl_read(11'h481, rd); chk("status_f2", rd, 32'h00020000);
    chk("irq_f2", irq_cnt, 2);

`ifdef VGA_TILE_SCROLL_EN
    // scroll: row 28 drawn at screen row 29, row 29 at screen row 0
    avl_write(11'h405, 32'h00000123, 4'hF);
    avl_write(11'h406, 32'h00000456, 4'hF);
    avl_write(11'd28, 32'h00000005, 4'hF);
    avl_write(11'd29, 32'h00000006, 4'hF);
    avl_write(11'h480, 32'h001D1ABC, 4'hF);
    avl_read(11'h480, rd); chk("scroll_rd", rd, 32'h001D1ABC);
    pix3(10'd0, 10'd464, 1'b1); chk("scroll_row29", rgb(), 32'h123);
    pix3(10'd0, 10'd0, 1'b1);   chk("scroll_row0", rgb(), 32'h456);
    avl_write(11'h480, 32'h00C81ABC, 4'hF);
    pix3(10'd0, 10'd464, 1'b1); chk("scroll_clamp", rgb(), 32'h123);
    avl_write(11'h480, 32'h00001ABC, 4'hF);
`endif

    // reset mid-frame
    pix3(10'd40, 10'd0, 1'b1); chk("pre_reset", rgb(), 32'hABC);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("reset_rgb", rgb(), 32'h0);
    RESET = 1'b0;
    chk("reset_readdata", AVL_READDATA, 32'h0);
    avl_read(11'h403, rd); chk("reset_pal3", rd, 32'h0);
    avl_write(11'h480, 32'h00001ABC, 4'hF);
    tick(10'd40, 10'd0, 1'b1); chk("refill_t1", rgb(), 32'h0);
    tick(10'd40, 10'd0, 1'b1); chk("refill_t2", rgb(), 32'h0);
    tick(10'd40, 10'd0, 1'b1); chk("refill_t3", rgb(), 32'hABC);
    avl_read(11'd5, rd); chk("ram_kept", rd, 32'h00B200D4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
